// File: rtl/pong_game_ctrl.sv
// Match sequencer for the pong datapath: serve timing, scoring, pause and
// end-of-match control. All outputs are registered.
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 120,
    parameter int POINT_FRAMES = 60,
    parameter int SCORE_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               pause,
    input  logic               miss_l,
    input  logic               miss_r,
    output logic               ball_en,
    output logic               ball_load,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state
);

    localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   SERVE_CNT = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   POINT_CNT = CNT_W'(POINT_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_POINT  = 3'd3,
        S_PAUSED = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d;
    logic [SCORE_W-1:0] score_p2_q, score_p2_d;
    logic               ball_en_q, ball_en_d;
    logic               ball_load_q, ball_load_d;
    logic               serve_dir_q, serve_dir_d;
    logic               game_over_q, game_over_d;
    logic               winner_q, winner_d;
    logic               start_q, pause_q;

    logic               start_rise, pause_rise;
    logic [SCORE_W-1:0] p1_inc, p2_inc;

    assign start_rise = start & ~start_q;
    assign pause_rise = pause & ~pause_q;
    assign p1_inc     = score_p1_q + SCORE_ONE;
    assign p2_inc     = score_p2_q + SCORE_ONE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        ball_en_d   = ball_en_q;
        ball_load_d = 1'b0;
        serve_dir_d = serve_dir_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                ball_en_d = 1'b0;
                if (start_rise) begin
                    state_d     = S_SERVE;
                    score_p1_d  = '0;
                    score_p2_d  = '0;
                    serve_dir_d = 1'b0;
                    cnt_d       = SERVE_CNT;
                    ball_load_d = 1'b1;
                    game_over_d = 1'b0;
                end
            end
            S_SERVE: begin
                ball_en_d = 1'b0;
                if (frame_tick) begin
                    if (cnt_q == CNT_ONE) begin
                        state_d   = S_PLAY;
                        ball_en_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            S_PLAY: begin
                ball_en_d = 1'b1;
                // A miss outranks a simultaneous pause press.
                if (miss_l && miss_r) begin
                    state_d   = S_POINT;
                    cnt_d     = POINT_CNT;
                    ball_en_d = 1'b0;
                end else if (miss_l) begin
                    ball_en_d   = 1'b0;
                    serve_dir_d = 1'b1;
                    if (p2_inc >= WIN_S) begin
                        score_p2_d  = WIN_S;
                        state_d     = S_OVER;
                        game_over_d = 1'b1;
                        winner_d    = 1'b1;
                    end else begin
                        score_p2_d = p2_inc;
                        state_d    = S_POINT;
                        cnt_d      = POINT_CNT;
                    end
                end else if (miss_r) begin
                    ball_en_d   = 1'b0;
                    serve_dir_d = 1'b0;
                    if (p1_inc >= WIN_S) begin
                        score_p1_d  = WIN_S;
                        state_d     = S_OVER;
                        game_over_d = 1'b1;
                        winner_d    = 1'b0;
                    end else begin
                        score_p1_d = p1_inc;
                        state_d    = S_POINT;
                        cnt_d      = POINT_CNT;
                    end
                end else if (pause_rise) begin
                    state_d   = S_PAUSED;
                    ball_en_d = 1'b0;
                end
            end
            S_POINT: begin
                ball_en_d = 1'b0;
                if (frame_tick) begin
                    if (cnt_q == CNT_ONE) begin
                        state_d     = S_SERVE;
                        cnt_d       = SERVE_CNT;
                        ball_load_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            S_PAUSED: begin
                ball_en_d = 1'b0;
                if (pause_rise) begin
                    state_d   = S_PLAY;
                    ball_en_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                ball_en_d = 1'b0;
            end
        endcase
    end

    // Button edge registers reset high so a button held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            score_p1_q  <= '0;
            score_p2_q  <= '0;
            ball_en_q   <= 1'b0;
            ball_load_q <= 1'b0;
            serve_dir_q <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            start_q     <= 1'b1;
            pause_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            score_p1_q  <= score_p1_d;
            score_p2_q  <= score_p2_d;
            ball_en_q   <= ball_en_d;
            ball_load_q <= ball_load_d;
            serve_dir_q <= serve_dir_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            start_q     <= start;
            pause_q     <= pause;
        end
    end

    assign ball_en   = ball_en_q;
    assign ball_load = ball_load_q;
    assign serve_dir = serve_dir_q;
    assign score_p1  = score_p1_q;
    assign score_p2  = score_p2_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with WIN_SCORE=3, SERVE_FRAMES=4, POINT_FRAMES=2.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic       pause;
    logic       miss_l;
    logic       miss_r;
    logic       ball_en;
    logic       ball_load;
    logic       serve_dir;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       game_over;
    logic       winner;
    logic [2:0] state;

    int vectors     = 0;
    int miscompares = 0;

    pong_game_ctrl #(
        .WIN_SCORE   (3),
        .SERVE_FRAMES(4),
        .POINT_FRAMES(2),
        .SCORE_W     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .start     (start),
        .pause     (pause),
        .miss_l    (miss_l),
        .miss_r    (miss_r),
        .ball_en   (ball_en),
        .ball_load (ball_load),
        .serve_dir (serve_dir),
        .score_p1  (score_p1),
        .score_p2  (score_p2),
        .game_over (game_over),
        .winner    (winner),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        miss_l = l;
        miss_r = r;
        step();
        miss_l = 1'b0;
        miss_r = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0; pause = 1'b0;
        miss_l = 1'b0; miss_r = 1'b0;
        step(); step(); step();
        reset = 1'b0;
        step();
        check("rst_state", state, 0);
        check("rst_p1", score_p1, 0);
        check("rst_p2", score_p2, 0);
        check("rst_ball_en", ball_en, 0);
        check("rst_ball_load", ball_load, 0);
        check("rst_game_over", game_over, 0);
        check("rst_serve_dir", serve_dir, 0);

        // Start a match and run through the serve countdown
        press_start();
        check("start_state", state, 1);
        check("start_load", ball_load, 1);
        check("start_en", ball_en, 0);
        step();
        check("load_one_cycle", ball_load, 0);
        ticks(3);
        check("serve_3ticks_state", state, 1);
        ticks(1);
        check("serve_done_state", state, 2);
        check("serve_done_en", ball_en, 1);
        check("play_p1", score_p1, 0);
        check("play_p2", score_p2, 0);

        // P2 concedes: point to P1
        pulse_miss(1'b0, 1'b1);
        check("missr_p1", score_p1, 1);
        check("missr_dir", serve_dir, 0);
        check("missr_state", state, 3);
        check("missr_en", ball_en, 0);
        ticks(1);
        check("point_1tick_state", state, 3);
        ticks(1);
        check("point_exp_state", state, 1);
        check("point_exp_load", ball_load, 1);
        step();
        check("point_exp_load_off", ball_load, 0);
        ticks(4);
        check("reserve_state", state, 2);

        // Three P1 misses end the match with P2 winning
        pulse_miss(1'b1, 1'b0);
        check("missl1_p2", score_p2, 1);
        check("missl1_dir", serve_dir, 1);
        ticks(6);
        pulse_miss(1'b1, 1'b0);
        check("missl2_p2", score_p2, 2);
        ticks(6);
        pulse_miss(1'b1, 1'b0);
        check("win_p2", score_p2, 3);
        check("win_state", state, 5);
        check("win_game_over", game_over, 1);
        check("win_winner", winner, 1);
        check("win_en", ball_en, 0);
        pulse_miss(1'b0, 1'b1);
        check("over_p1_hold", score_p1, 1);
        check("over_p2_hold", score_p2, 3);
        check("over_state_hold", state, 5);

        // Restart from OVER
        press_start();
        check("restart_state", state, 1);
        check("restart_game_over", game_over, 0);
        check("restart_p1", score_p1, 0);
        check("restart_p2", score_p2, 0);
        check("restart_load", ball_load, 1);
        check("restart_dir", serve_dir, 0);
        ticks(4);
        check("restart_play", state, 2);

        // Double miss is a replay and keeps serve direction
        pulse_miss(1'b1, 1'b0);
        ticks(6);
        check("pre_dbl_state", state, 2);
        pulse_miss(1'b1, 1'b1);
        check("dbl_p1", score_p1, 0);
        check("dbl_p2", score_p2, 1);
        check("dbl_state", state, 3);
        check("dbl_dir", serve_dir, 1);
        ticks(6);
        check("dbl_back_play", state, 2);

        // Pause and resume
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("pause_state", state, 4);
        check("pause_en", ball_en, 0);
        ticks(10);
        check("pause_ticks_state", state, 4);
        pulse_miss(1'b1, 1'b0);
        check("pause_miss_p2", score_p2, 1);
        check("pause_miss_state", state, 4);
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("resume_state", state, 2);
        check("resume_en", ball_en, 1);
        check("resume_no_load", ball_load, 0);
        step();
        pause = 1'b1;
        miss_r = 1'b1;
        step();
        pause = 1'b0;
        miss_r = 1'b0;
        check("pause_miss_prio_p1", score_p1, 1);
        check("pause_miss_prio_state", state, 3);
        ticks(6);
        pulse_miss(1'b0, 1'b1);
        check("p1_two", score_p1, 2);
        ticks(6);
        check("pre_reset_play", state, 2);

        // Reset mid-match, with start held through reset
        reset = 1'b1;
        step();
        check("midrst_state", state, 0);
        check("midrst_p1", score_p1, 0);
        check("midrst_p2", score_p2, 0);
        check("midrst_en", ball_en, 0);
        check("midrst_load", ball_load, 0);
        start = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        check("held_start_idle", state, 0);
        start = 1'b0;
        step();
        press_start();
        check("release_press_serve", state, 1);
        check("release_press_load", ball_load, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
